// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, instruction field positions and hazard FSM state type
package pipe_pkg;

  localparam int INST_W = 19;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;

  localparam int DEST_MSB = 13;
  localparam int DEST_LSB = 11;
  localparam int SRC1_MSB = 10;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 5;

  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline-to-hazard-unit signal bundle (counters under HAZARD_PERF_CNT_EN)
interface hazard_stall_unit_if;
  import pipe_pkg::*;

  logic [INST_W-1:0] ID_inst;
  logic              reg2_read_source;
  logic [INST_W-1:0] EX_inst;
  logic              EX_mem_read_signal;
  logic              MEM_mem_access;
  logic              mem_ready;
  logic              branch_taken;
  logic              PC_write;
  logic              IF_ID_write;
  logic              IF_ID_flush;
  logic              ID_EX_bubble;
  logic              pipe_freeze;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  lu_stall_cnt;
  logic [CNT_W-1:0]  mem_stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  modport master (
    output ID_inst, reg2_read_source, EX_inst, EX_mem_read_signal,
           MEM_mem_access, mem_ready, branch_taken,
`ifdef HAZARD_PERF_CNT_EN
    input  lu_stall_cnt, mem_stall_cnt, flush_cnt,
`endif
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze
  );

  modport slave (
    input  ID_inst, reg2_read_source, EX_inst, EX_mem_read_signal,
           MEM_mem_access, mem_ready, branch_taken,
`ifdef HAZARD_PERF_CNT_EN
    output lu_stall_cnt, mem_stall_cnt, flush_cnt,
`endif
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze
  );

endinterface

// File: rtl/hazard_compare.sv
// rtl/hazard_compare.sv - combinational EX-destination vs ID-source compare for load-use detection
module hazard_compare
  import pipe_pkg::*;
(
  input  logic [INST_W-1:0] id_inst,
  input  logic [INST_W-1:0] ex_inst,
  input  logic              reg2_read_source,
  input  logic              ex_mem_read_signal,
  output logic              lu_hit
);

  logic [REG_AW-1:0] dest;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              unused_bits;

  assign dest = ex_inst[DEST_MSB:DEST_LSB];
  assign src1 = id_inst[SRC1_MSB:SRC1_LSB];
  assign src2 = reg2_read_source ? id_inst[SRC1_MSB:SRC1_LSB] : id_inst[SRC2_MSB:SRC2_LSB];

  // r0 is hardwired zero, so a load targeting it can never feed a consumer
  assign lu_hit = ex_mem_read_signal && (dest != '0) && ((dest == src1) || (dest == src2));

  assign unused_bits = ^{id_inst[INST_W-1:SRC1_MSB+1], id_inst[SRC2_LSB-1:0],
                         ex_inst[INST_W-1:DEST_MSB+1], ex_inst[DEST_LSB-1:0]};

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush controller for load-use, memory wait and taken branch
// Optional stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit
  import pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  hazard_stall_unit_if.slave bus
);

  state_t state;
  logic   lu_pending;
  logic   br_pending;
  logic   lu_hit;
  logic   mw_hit;

  hazard_compare u_compare (
    .id_inst            (bus.ID_inst),
    .ex_inst            (bus.EX_inst),
    .reg2_read_source   (bus.reg2_read_source),
    .ex_mem_read_signal (bus.EX_mem_read_signal),
    .lu_hit             (lu_hit)
  );

  assign mw_hit = bus.MEM_mem_access && !bus.mem_ready;

  // Priority: memory wait, then branch flush, then load-use bubble
  always_comb begin
    bus.PC_write     = 1'b1;
    bus.IF_ID_write  = 1'b1;
    bus.IF_ID_flush  = 1'b0;
    bus.ID_EX_bubble = 1'b0;
    bus.pipe_freeze  = 1'b0;
    if (!rst) begin
      if (((state == RUN) && mw_hit) || ((state == MEM_WAIT) && !bus.mem_ready)) begin
        bus.PC_write    = 1'b0;
        bus.IF_ID_write = 1'b0;
        bus.pipe_freeze = 1'b1;
      end else if ((state == RUN) && (bus.branch_taken || br_pending)) begin
        bus.IF_ID_flush  = 1'b1;
        bus.ID_EX_bubble = 1'b1;
      end else if ((state == RUN) && (lu_hit || lu_pending)) begin
        bus.PC_write     = 1'b0;
        bus.IF_ID_write  = 1'b0;
        bus.ID_EX_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      lu_pending <= 1'b0;
      br_pending <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mw_hit) begin
            state <= MEM_WAIT;
            if (lu_hit)           lu_pending <= 1'b1;
            if (bus.branch_taken) br_pending <= 1'b1;
          end else if (bus.branch_taken || br_pending) begin
            // the flush discards the dependent instruction, so its bubble is moot
            br_pending <= 1'b0;
            lu_pending <= 1'b0;
          end else if (lu_hit || lu_pending) begin
            lu_pending <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mem_cnt;
  logic [CNT_W-1:0] fl_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt  <= '0;
      mem_cnt <= '0;
      fl_cnt  <= '0;
    end else begin
      if (bus.ID_EX_bubble && !bus.IF_ID_flush && (lu_cnt != '1)) lu_cnt <= lu_cnt + CNT_W'(1);
      if (bus.pipe_freeze && (mem_cnt != '1)) mem_cnt <= mem_cnt + CNT_W'(1);
      if (bus.IF_ID_flush && (fl_cnt != '1))  fl_cnt  <= fl_cnt + CNT_W'(1);
    end
  end

  assign bus.lu_stall_cnt  = lu_cnt;
  assign bus.mem_stall_cnt = mem_cnt;
  assign bus.flush_cnt     = fl_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed and randomized checks of hazard_stall_unit against a cycle model
module tb_hazard_stall_unit;
  import pipe_pkg::*;

  localparam int A_RUN = 0;
  localparam int A_FRZ = 1;
  localparam int A_FLS = 2;
  localparam int A_BUB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_unit_if bus ();

  hazard_stall_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit m_wait, m_lu, m_br;
  int m_luc, m_memc, m_flc;

  function automatic logic [INST_W-1:0] mk(input int d, input int s1, input int s2);
    return INST_W'(d * 2048 + s1 * 256 + s2 * 32);
  endfunction

  function automatic bit ref_hit();
    int dest, s1, s2;
    dest = (int'(bus.EX_inst) / 2048) % 8;
    s1   = (int'(bus.ID_inst) / 256) % 8;
    s2   = bus.reg2_read_source ? s1 : (int'(bus.ID_inst) / 32) % 8;
    return bus.EX_mem_read_signal && dest != 0 && (dest == s1 || dest == s2);
  endfunction

  function automatic int ref_act();
    if (rst) return A_RUN;
    if (m_wait) return bus.mem_ready ? A_RUN : A_FRZ;
    if (bus.MEM_mem_access && !bus.mem_ready) return A_FRZ;
    if (bus.branch_taken || m_br) return A_FLS;
    if (ref_hit() || m_lu) return A_BUB;
    return A_RUN;
  endfunction

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze}
  function automatic logic [4:0] outs_of(input int a);
    case (a)
      A_FRZ:   return 5'b00001;
      A_FLS:   return 5'b11110;
      A_BUB:   return 5'b00010;
      default: return 5'b11000;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic step(input int exp_act, input string tag);
    int a;
    logic [4:0] got, exp;
    bit n_wait, n_lu, n_br, hit, mw;
    @(negedge clk);
    a   = ref_act();
    exp = outs_of(exp_act >= 0 ? exp_act : a);
    got = {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_bubble, bus.pipe_freeze};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: outputs got=%b exp=%b", tag, got, exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert ({bus.lu_stall_cnt, bus.mem_stall_cnt, bus.flush_cnt} ===
            {CNT_W'(m_luc), CNT_W'(m_memc), CNT_W'(m_flc)}) else begin
      failures++;
      $error("FAIL %s_cnt: got=%0d/%0d/%0d exp=%0d/%0d/%0d", tag, bus.lu_stall_cnt,
             bus.mem_stall_cnt, bus.flush_cnt, m_luc, m_memc, m_flc);
    end
`endif
    hit = ref_hit();
    mw  = bus.MEM_mem_access && !bus.mem_ready;
    n_wait = m_wait; n_lu = m_lu; n_br = m_br;
    if (rst) begin
      n_wait = 0; n_lu = 0; n_br = 0;
    end else if (m_wait) begin
      if (bus.mem_ready) n_wait = 0;
    end else if (mw) begin
      n_wait = 1; n_lu = m_lu | hit; n_br = m_br | bus.branch_taken;
    end else if (bus.branch_taken || m_br) begin
      n_lu = 0; n_br = 0;
    end else if (hit || m_lu) begin
      n_lu = 0;
    end
    @(posedge clk);
    m_wait = n_wait; m_lu = n_lu; m_br = n_br;
    if (rst) begin
      m_luc = 0; m_memc = 0; m_flc = 0;
    end else begin
      if (a == A_BUB) m_luc  = sat(m_luc);
      if (a == A_FRZ) m_memc = sat(m_memc);
      if (a == A_FLS) m_flc  = sat(m_flc);
    end
    #1;
  endtask

  task automatic check_state(input state_t exp, input string tag);
    checks++;
    assert (dut.state === exp) else begin
      failures++;
      $error("FAIL %s: state got=%0d exp=%0d", tag, dut.state, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ID_inst = NOP_INST; bus.EX_inst = NOP_INST; bus.reg2_read_source = 0;
    bus.EX_mem_read_signal = 0; bus.MEM_mem_access = 0; bus.mem_ready = 0;
    bus.branch_taken = 0;
  endtask

  initial begin
    m_wait = 0; m_lu = 0; m_br = 0; m_luc = 0; m_memc = 0; m_flc = 0;
    idle_inputs();
    rst = 1;
    // hazards presented during reset must not leak onto the outputs
    bus.MEM_mem_access = 1; bus.branch_taken = 1;
    step(A_RUN, "rst_outputs");
    idle_inputs(); rst = 0;
    step(A_RUN, "idle");
    check_state(RUN, "idle_state");

    bus.EX_inst = mk(2, 0, 0); bus.EX_mem_read_signal = 1; bus.ID_inst = mk(3, 2, 4);
    step(A_BUB, "lu_src1");
    bus.EX_inst = NOP_INST; bus.EX_mem_read_signal = 0;
    step(A_RUN, "lu_after");
    bus.EX_inst = mk(4, 0, 0); bus.EX_mem_read_signal = 1;
    step(A_BUB, "lu_src2");
    bus.reg2_read_source = 1;
    step(A_RUN, "r2s_sel");
    bus.reg2_read_source = 0;
    bus.EX_inst = mk(0, 0, 0); bus.ID_inst = mk(1, 0, 0);
    step(A_RUN, "dest_zero");
    bus.EX_inst = mk(5, 0, 0); bus.ID_inst = mk(3, 1, 2);
    step(A_RUN, "no_reader");

    bus.EX_inst = mk(1, 0, 0); bus.ID_inst = mk(2, 1, 0);
    step(A_BUB, "b2b_first");
    bus.EX_inst = NOP_INST; bus.EX_mem_read_signal = 0;
    step(A_RUN, "b2b_gap");
    bus.EX_inst = mk(2, 0, 0); bus.EX_mem_read_signal = 1; bus.ID_inst = mk(3, 2, 2);
    step(A_BUB, "b2b_second");
    idle_inputs();
    step(A_RUN, "b2b_done");

    bus.MEM_mem_access = 1; bus.mem_ready = 1;
    step(A_RUN, "zero_wait");
    bus.mem_ready = 0;
    step(A_FRZ, "mw_1");
    check_state(MEM_WAIT, "mw_state");
    step(A_FRZ, "mw_2");
    step(A_FRZ, "mw_3");
    bus.mem_ready = 1;
    step(A_RUN, "mw_release");
    check_state(RUN, "mw_run");
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert (bus.mem_stall_cnt === CNT_W'(3)) else begin
      failures++;
      $error("FAIL mem_cnt3: got=%0d exp=3", bus.mem_stall_cnt);
    end
`endif
    idle_inputs();

    bus.EX_inst = mk(2, 0, 0); bus.EX_mem_read_signal = 1; bus.ID_inst = mk(3, 2, 4);
    bus.branch_taken = 1;
    step(A_FLS, "br_over_lu");
    bus.branch_taken = 0; bus.EX_inst = NOP_INST; bus.EX_mem_read_signal = 0;
    step(A_RUN, "br_no_extra");

    bus.EX_inst = mk(2, 0, 0); bus.EX_mem_read_signal = 1;
    bus.MEM_mem_access = 1; bus.mem_ready = 0;
    step(A_FRZ, "mwlu_1");
    step(A_FRZ, "mwlu_2");
    bus.mem_ready = 1;
    step(A_RUN, "mwlu_release");
    idle_inputs(); bus.ID_inst = mk(3, 2, 4);
    step(A_BUB, "lu_pending");
    step(A_RUN, "lu_pending_done");

    bus.MEM_mem_access = 1; bus.branch_taken = 1;
    step(A_FRZ, "mwbr_1");
    bus.branch_taken = 0; bus.mem_ready = 1;
    step(A_RUN, "mwbr_release");
    idle_inputs();
    step(A_FLS, "br_pending");

    bus.MEM_mem_access = 1; bus.branch_taken = 1;
    bus.EX_inst = mk(2, 0, 0); bus.EX_mem_read_signal = 1; bus.ID_inst = mk(3, 2, 4);
    step(A_FRZ, "rstw_1");
    step(A_FRZ, "rstw_2");
    rst = 1;
    step(A_RUN, "rst_in_wait");
    rst = 0; idle_inputs(); bus.ID_inst = mk(3, 2, 4);
    step(A_RUN, "pending_cleared");
    check_state(RUN, "rst_state");

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.EX_inst = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      bus.ID_inst = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      bus.reg2_read_source   = $urandom_range(0, 1) == 1;
      bus.EX_mem_read_signal = $urandom_range(0, 1) == 1;
      bus.MEM_mem_access     = $urandom_range(0, 2) == 0;
      bus.mem_ready          = $urandom_range(0, 1) == 1;
      bus.branch_taken       = $urandom_range(0, 6) == 0;
      step(-1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage 19-bit MIPS pipeline.
- Covers the hazards operand forwarding cannot resolve:
  - load-use: inserts one bubble, after which the forwarding path supplies the MEM-stage value;
  - multi-cycle data-memory access: freezes the pipeline until the ready handshake;
  - taken branch resolved in EX: flushes IF/ID and ID/EX.
- Sits beside the forwarding logic in the ID stage and drives the pipeline-register write enables and the PC write enable.

Parameters:
- INST_W, 19, instruction width.
- REG_AW, 3, register-address width. Register 0 is hardwired zero and never causes a hazard.
- CNT_W, 16, width of the stall counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ID_inst  in  INST_W  instruction in ID. src1 = [10:8]; src2 = reg2_read_source ? [10:8] : [7:5].
- reg2_read_source  in  1  second-operand source select.
- EX_inst  in  INST_W  instruction in EX; destination at [13:11].
- EX_mem_read_signal  in  1  EX instruction is a load.
- MEM_mem_access  in  1  MEM instruction reads or writes data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register write enable.
- IF_ID_flush  out  1  clear IF/ID to NOP.
- ID_EX_bubble  out  1  load NOP into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.

Behaviour:
- Registered state: state ∈ {RUN, MEM_WAIT}, plus flag lu_pending. Outputs are combinational from registered state and current inputs.
- During and after reset (rst=1 on a clk edge): state=RUN, lu_pending=0.
- Output values while rst=1: PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, pipe_freeze=0.
- lu_hit = EX_mem_read_signal & EX_inst[13:11]!=0 & (EX_inst[13:11]==src1 | EX_inst[13:11]==src2).
- mw_hit = MEM_mem_access & ~mem_ready.
- Priority each cycle: mem wait > branch > load-use.
- RUN, mw_hit:
  - pipe_freeze=1, PC_write=0, IF_ID_write=0, no bubble, no flush.
  - If lu_hit or branch_taken is also true, set lu_pending=1 or record br_pending=1 respectively.
  - Next state MEM_WAIT.
- RUN, branch_taken (or br_pending), no mw_hit:
  - IF_ID_flush=1, ID_EX_bubble=1, PC_write=1 (loads target).
  - Clears br_pending and lu_pending; the flush supersedes the load-use.
- RUN, (lu_hit | lu_pending), no mw_hit, no branch:
  - PC_write=0, IF_ID_write=0, ID_EX_bubble=1 for exactly one cycle; clears lu_pending.
  - The next cycle has EX = bubble, so no re-detection.
- RUN, otherwise: all enables 1, flush/bubble/freeze 0.
- MEM_WAIT:
  - Outputs as for mw_hit while ~mem_ready.
  - On mem_ready=1: freeze is released that same cycle and the next state is RUN.
  - Pending branch or load-use is serviced in the following RUN cycle.
- mem_ready=1 on the first access cycle: no stall (zero-wait memory).
- Back-to-back load-use (lw r1; lw r2,0(r1); add r3,r2,r2): one bubble each, two total.
- Reset mid-MEM_WAIT: returns to RUN, pending flags cleared. The memory controller is reset by the same rst.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three outputs, each CNT_W wide:
  - lu_stall_cnt: increments on every load-use bubble cycle.
  - mem_stall_cnt: increments on every freeze cycle.
  - flush_cnt: increments on every branch flush.
- Counters saturate at all-ones, not wrap, and reset to 0.
- When undefined: ports and registers absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - field positions DEST_MSB/LSB=13/11, SRC1=10/8, SRC2=7/5;
  - REG_AW, INST_W, NOP encoding;
  - state enum {RUN, MEM_WAIT}.
- The forwarding logic uses the same field constants.
- One natural sub-module: hazard_compare. It is combinational and produces lu_hit from ID_inst, EX_inst, reg2_read_source and EX_mem_read_signal; it is reusable for the forwarding compare.

Test Plan:
1. lw r2 in EX, ID add r3,r2,r4, reg2_read_source=0 -> one cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle all enables 1.
2. lw r0 in EX (dest 0), ID uses r0 -> no stall; a load to a register the ID instruction does not read -> no stall.
3. MEM_mem_access=1, mem_ready low for 3 cycles -> pipe_freeze=1 for exactly 3 cycles, state MEM_WAIT. With HAZARD_PERF_CNT_EN defined, mem_stall_cnt=3.
4. branch_taken=1 together with lu_hit -> IF_ID_flush=1 and ID_EX_bubble=1 in one cycle; no extra load-use stall afterwards.
5. mw_hit with lu_hit in the same cycle, mem_ready after 2 cycles -> 2 freeze cycles, then exactly one bubble cycle.
6. rst=1 asserted during MEM_WAIT -> next cycle state RUN, all enables 1, pending cleared, counters 0.
